// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_RANGE    = 2'd2
    } fault_code_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, decode handshake, redirect/halt
// control and fault status. master = fetch controller, slave = its peers.
interface instr_fetch_ctrl_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, fault, fault_code,
        input  imem_data, out_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, fault, fault_code,
        output imem_data, out_ready, redirect_valid, redirect_pc, halt
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries. Flush wins over push/pop.
// Head outputs read as zero while the buffer is empty.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [31:0]   push_pc_i,
    input  logic [31:0]   push_instr_i,
    output logic [CW-1:0] count_o,
    output logic [31:0]   head_pc_o,
    output logic [31:0]   head_instr_o
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_i && !pop_i)      count_q <= count_q + CW'(1);
            else if (pop_i && !push_i) count_q <= count_q - CW'(1);
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = (count_q != '0) ? pc_mem_q[rd_ptr_q]    : '0;
    assign head_instr_o = (count_q != '0) ? instr_mem_q[rd_ptr_q] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push_i && !pop_i && !flush_i && count_q == FULL_CNT));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop_i && !flush_i && count_q == '0));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC register, fetch FSM, redirect priority
// and sticky fault reporting in front of a small prefetch buffer.
//
//   state | meaning
//   IDLE  | one cycle after reset, no fetch
//   FETCH | push {PC, imem_data} whenever the buffer can take it
//   HALT  | no fetch, buffer keeps draining, redirects still load PC
//   FAULT | sticky until reset; outputs silenced, inputs ignored
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          ROM_WORDS = 64,
    parameter int          DEPTH     = 2
) (
    input logic                clk,
    input logic                reset_n,
    instr_fetch_ctrl_if.master bus
);

    localparam int          CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

    fetch_state_e  state_q;
    logic [31:0]   pc_q;
    logic          fault_q;
    fault_code_e   fault_code_q;

    logic [CW-1:0] count;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;
    logic          misaligned;
    logic          redirect_act;
    logic          fetch_go;
    logic          push;
    logic          pop;
    logic          flush;
    logic          range_fault;

    assign misaligned   = (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_act = bus.redirect_valid && (state_q == FETCH || state_q == HALT);

    assign bus.out_valid = (count != '0) && !bus.redirect_valid && (state_q != FAULT);
    assign pop           = bus.out_valid && bus.out_ready;

    // A fetch is due when the buffer has room (or frees a slot this cycle);
    // whether it pushes or faults then depends only on the PC range.
    assign fetch_go    = (state_q == FETCH) && !bus.redirect_valid && !bus.halt
                         && ((count < FULL_CNT) || pop);
    assign push        = fetch_go && (pc_q < ROM_BYTES);
    assign range_fault = fetch_go && !(pc_q < ROM_BYTES);
    assign flush       = redirect_act || range_fault;

    // Fetch FSM with PC and fault registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (bus.redirect_valid) begin
                        if (misaligned) begin
                            state_q      <= FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_MISALIGN;
                        end else begin
                            pc_q <= bus.redirect_pc;
                        end
                    end else if (bus.halt) begin
                        state_q <= HALT;
                    end else if (range_fault) begin
                        state_q      <= FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_RANGE;
                    end else if (push) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                HALT: begin
                    if (bus.redirect_valid) begin
                        if (misaligned) begin
                            state_q      <= FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_MISALIGN;
                        end else begin
                            pc_q <= bus.redirect_pc;
                        end
                    end else if (!bus.halt) begin
                        state_q <= FETCH;
                    end
                end
                FAULT: state_q <= FAULT;
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush),
        .push_pc_i    (pc_q),
        .push_instr_i (bus.imem_data),
        .count_o      (count),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.out_pc     = head_pc;
    assign bus.out_instr  = head_instr;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: stream, back-pressure, redirect,
// misaligned redirect, out-of-range PC and halt/drain scenarios.
module tb_instr_fetch_ctrl;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .ROM_WORDS (64),
        .DEPTH     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0052_0333;
            32'h4:   return 32'h4021_84b3;
            32'h8:   return 32'h0060_2503;
            default: return 32'h1300_0000 | a;
        endcase
    endfunction

    assign bus.imem_data = rom_word(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic do_reset(input logic ready);
        bus.out_ready      = ready;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt           = 1'b0;
        reset_n            = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt           = 1'b0;

        // Reset values, then a straight stream with out_ready held high.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_addr",  bus.imem_addr, 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pc",    bus.out_pc, 32'h0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_code",  32'(bus.fault_code), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("s_idle_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("s_valid0", 32'(bus.out_valid), 32'd1);
        check("s_pc0",    bus.out_pc, 32'h0);
        check("s_ins0",   bus.out_instr, 32'h0052_0333);
        @(negedge clk);
        check("s_pc4",    bus.out_pc, 32'h4);
        check("s_ins4",   bus.out_instr, 32'h4021_84b3);
        @(negedge clk);
        check("s_pc8",    bus.out_pc, 32'h8);
        check("s_ins8",   bus.out_instr, 32'h0060_2503);

        // Back-pressure: buffer fills to two, PC parks at 0x8.
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        check("bp_pc",    bus.out_pc, 32'h0);
        check("bp_addr",  bus.imem_addr, 32'h8);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_pc4",   bus.out_pc, 32'h4);
        check("bp_v4",    32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("bp_pc8",   bus.out_pc, 32'h8);
        check("bp_v8",    32'(bus.out_valid), 32'd1);

        // Redirect to 0x20 with 0x4 and 0x8 buffered.
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rd_pc4", bus.out_pc, 32'h4);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("rd_pre_pc",   bus.out_pc, 32'h4);
        check("rd_pre_addr", bus.imem_addr, 32'hC);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        bus.out_ready      = 1'b1;
        #1;
        check("rd_valid_n", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("rd_valid_n1", 32'(bus.out_valid), 32'd0);
        check("rd_addr",     bus.imem_addr, 32'h20);
        @(negedge clk);
        check("rd_valid_n2", 32'(bus.out_valid), 32'd1);
        check("rd_pc20",     bus.out_pc, 32'h20);
        check("rd_ins20",    bus.out_instr, 32'h1300_0020);
        @(negedge clk);
        check("rd_pc24",     bus.out_pc, 32'h24);

        // Misaligned redirect: sticky fault, later redirect ignored.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h22;
        #1;
        check("ma_valid_n", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.redirect_pc = 32'h0;
        #1;
        check("ma_fault", 32'(bus.fault), 32'd1);
        check("ma_code",  32'(bus.fault_code), 32'd1);
        check("ma_valid", 32'(bus.out_valid), 32'd0);
        check("ma_addr",  bus.imem_addr, 32'h28);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("ma_fault2", 32'(bus.fault), 32'd1);
        check("ma_code2",  32'(bus.fault_code), 32'd1);
        check("ma_addr2",  bus.imem_addr, 32'h28);
        check("ma_valid2", 32'(bus.out_valid), 32'd0);
        reset_n = 1'b0;
        #1;
        check("ma_rst_fault", 32'(bus.fault), 32'd0);
        check("ma_rst_code",  32'(bus.fault_code), 32'd0);
        check("ma_rst_addr",  bus.imem_addr, 32'h0);

        // Out-of-range: 0xFC delivered, fault once PC reaches 0x100.
        do_reset(1'b1);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("or_valid0", 32'(bus.out_valid), 32'd0);
        check("or_addr",   bus.imem_addr, 32'hFC);
        @(negedge clk);
        check("or_valid1", 32'(bus.out_valid), 32'd1);
        check("or_pcfc",   bus.out_pc, 32'hFC);
        check("or_insfc",  bus.out_instr, 32'h1300_00FC);
        check("or_nofault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        check("or_fault", 32'(bus.fault), 32'd1);
        check("or_code",  32'(bus.fault_code), 32'd2);
        check("or_valid", 32'(bus.out_valid), 32'd0);
        check("or_pc",    bus.out_pc, 32'h0);
        @(negedge clk);
        check("or_valid2", 32'(bus.out_valid), 32'd0);
        check("or_code2",  32'(bus.fault_code), 32'd2);

        // Halt for 4 cycles with two entries buffered: drain, then resume.
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        bus.halt      = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("h_valid0", 32'(bus.out_valid), 32'd1);
        check("h_pc0",    bus.out_pc, 32'h0);
        @(negedge clk);
        check("h_valid4", 32'(bus.out_valid), 32'd1);
        check("h_pc4",    bus.out_pc, 32'h4);
        @(negedge clk);
        check("h_drained", 32'(bus.out_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("h_still", 32'(bus.out_valid), 32'd0);
        check("h_addr",  bus.imem_addr, 32'h8);
        bus.halt = 1'b0;
        @(negedge clk);
        check("h_resume0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("h_resume1", 32'(bus.out_valid), 32'd1);
        check("h_pc8",     bus.out_pc, 32'h8);
        check("h_ins8",    bus.out_instr, 32'h0060_2503);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
